fixp_mult_pipe: RTL and testbench

//  Pipelined signed fixed-point multiplier for the FIR tap datapath.

---
 rtl/fixp_mult_pipe.sv | 147 ++++++++++++++
 tb/tb_fixp_mult_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixp_mult_pipe.sv
// Three-stage signed fixed-point multiplier: two's-complement sample times sign-magnitude coefficient,
// with per-item rounding/saturation modes and a globally stalled valid/ready pipeline.
module fixp_mult_pipe #(
    parameter int N = 16,
    parameter int Q = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N:0]   in_b,
    input  logic         rnd_en,
    input  logic         sat_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_p,
    output logic         out_ovf
);

    // Width of the shifted magnitude; one bit wider than P>>Q so the rounding carry survives.
    localparam int MW = 2*N - Q + 1;

    localparam logic [2*N:0]  RND_HALF = (2*N+1)'(1) << (Q-1);
    localparam logic [MW-1:0] POS_LIM  = {{(MW-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic [MW-1:0] NEG_LIM  = POS_LIM + MW'(1);
    localparam logic [N-1:0]  SAT_POS  = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  SAT_NEG  = {1'b1, {(N-1){1'b0}}};

    logic adv;

    // Stage 1: magnitudes and result sign
    logic         v1_q,   v1_d;
    logic [N-1:0] ma1_q,  ma1_d;
    logic [N-1:0] mb1_q,  mb1_d;
    logic         s1_q,   s1_d;
    logic         rnd1_q, rnd1_d;
    logic         sat1_q, sat1_d;

    // Stage 2: unsigned product
    logic           v2_q,   v2_d;
    logic [2*N-1:0] p2_q,   p2_d;
    logic           s2_q,   s2_d;
    logic           rnd2_q, rnd2_d;
    logic           sat2_q, sat2_d;

    // Stage 3: final result
    logic         v3_q,    v3_d;
    logic [N-1:0] out_p_q, out_p_d;
    logic         ovf_q,   ovf_d;

    logic [2*N:0]  sum3;
    logic [MW-1:0] m3;
    logic [MW-1:0] m3_neg;
    logic [N-1:0]  r3;
    logic          ovf3;
    logic [N-1:0]  res3;

    assign adv      = !v3_q | out_ready;
    assign in_ready = adv;

    assign out_valid = v3_q;
    assign out_p     = out_p_q;
    assign out_ovf   = ovf_q;

    always_comb begin
        sum3   = {1'b0, p2_q} + (rnd2_q ? RND_HALF : '0);
        m3     = sum3[2*N:Q];
        m3_neg = '0 - m3;
        // -0 is 0 in two's complement, so a zero magnitude never yields a negative result
        r3     = s2_q ? m3_neg[N-1:0] : m3[N-1:0];
        ovf3   = s2_q ? (m3 > NEG_LIM) : (m3 > POS_LIM);
        if (ovf3 && sat2_q) begin
            res3 = s2_q ? SAT_NEG : SAT_POS;
        end else begin
            res3 = r3;
        end
    end

    always_comb begin
        v1_d    = v1_q;
        ma1_d   = ma1_q;
        mb1_d   = mb1_q;
        s1_d    = s1_q;
        rnd1_d  = rnd1_q;
        sat1_d  = sat1_q;
        v2_d    = v2_q;
        p2_d    = p2_q;
        s2_d    = s2_q;
        rnd2_d  = rnd2_q;
        sat2_d  = sat2_q;
        v3_d    = v3_q;
        out_p_d = out_p_q;
        ovf_d   = ovf_q;
        if (adv) begin
            v1_d    = in_valid;
            ma1_d   = in_a[N-1] ? ('0 - in_a) : in_a;
            mb1_d   = in_b[N-1:0];
            s1_d    = in_a[N-1] ^ in_b[N];
            rnd1_d  = rnd_en;
            sat1_d  = sat_en;
            v2_d    = v1_q;
            p2_d    = {{N{1'b0}}, ma1_q} * {{N{1'b0}}, mb1_q};
            s2_d    = s1_q;
            rnd2_d  = rnd1_q;
            sat2_d  = sat1_q;
            v3_d    = v2_q;
            out_p_d = res3;
            ovf_d   = ovf3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            ma1_q   <= '0;
            mb1_q   <= '0;
            s1_q    <= 1'b0;
            rnd1_q  <= 1'b0;
            sat1_q  <= 1'b0;
            v2_q    <= 1'b0;
            p2_q    <= '0;
            s2_q    <= 1'b0;
            rnd2_q  <= 1'b0;
            sat2_q  <= 1'b0;
            v3_q    <= 1'b0;
            out_p_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            ma1_q   <= ma1_d;
            mb1_q   <= mb1_d;
            s1_q    <= s1_d;
            rnd1_q  <= rnd1_d;
            sat1_q  <= sat1_d;
            v2_q    <= v2_d;
            p2_q    <= p2_d;
            s2_q    <= s2_d;
            rnd2_q  <= rnd2_d;
            sat2_q  <= sat2_d;
            v3_q    <= v3_d;
            out_p_q <= out_p_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fixp_mult_pipe.sv
// Scoreboard bench for fixp_mult_pipe (N=16, Q=14): directed vectors, backpressure, reset and a random stream.
module tb_fixp_mult_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [16:0] in_b = '0;
    logic        rnd_en = 1'b0;
    logic        sat_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_p;
    logic        out_ovf;

    typedef struct packed {
        logic [15:0] p;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [16:0] b;
        logic        rnd;
        logic        sat;
        logic [15:0] p;
        logic        ovf;
    } vec_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   bp_mode = 0;   // 0: out_ready=1, 1: out_ready=0, 2: random

    fixp_mult_pipe #(.N(16), .Q(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .rnd_en    (rnd_en),
        .sat_en    (sat_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: a transfer happens at the next rising edge when out_valid & out_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {15'd0, out_ovf, out_p}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_p", {16'd0, out_p}, {16'd0, e.p});
                    chk("out_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [16:0] b, input logic rnd,
                        input logic sat, input logic [15:0] ep, input logic eo);
        @(negedge clk);
        in_a = a; in_b = b; rnd_en = rnd; sat_en = sat; in_valid = 1'b1;
        for (int w = 0; w < 2000; w++) begin
            #1;
            if (in_ready) begin
                exp_q.push_back('{p: ep, ovf: eo});
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bp_mode = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0) break;
        end
        chk("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    task automatic latency_check(input logic [15:0] a, input logic [16:0] b,
                                 input logic [15:0] ep, input logic eo);
        int n;
        n = 0;
        @(negedge clk);
        in_a = a; in_b = b; rnd_en = 1'b0; sat_en = 1'b0; in_valid = 1'b1;
        #1;
        chk("lat_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.push_back('{p: ep, ovf: eo});
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) in_valid = 1'b0;
            if (out_valid) begin
                n = c;
                break;
            end
        end
        chk("latency_cycles", n, 32'd3);
    endtask

    function automatic void model(input logic [15:0] a, input logic [16:0] b, input logic rnd,
                                  input logic sat, output logic [15:0] p, output logic ovf);
        longint av, prod, absp, m, r;
        av   = longint'($signed(a));
        prod = av * longint'(b[15:0]);
        if (b[16]) prod = -prod;
        absp = (prod < 0) ? -prod : prod;
        m    = rnd ? (absp + 8192) / 16384 : absp / 16384;
        r    = (prod < 0) ? -m : m;
        ovf  = (r > 32767) || (r < -32768);
        if (ovf && sat) p = (r < 0) ? 16'h8000 : 16'h7FFF;
        else            p = r[15:0];
    endfunction

    vec_t dir_vecs[$] = '{
        '{a: 16'h4000, b: 17'h0_2000, rnd: 1'b0, sat: 1'b0, p: 16'h2000, ovf: 1'b0},
        '{a: 16'h4000, b: 17'h1_2000, rnd: 1'b0, sat: 1'b0, p: 16'hE000, ovf: 1'b0},
        '{a: 16'h0001, b: 17'h0_2000, rnd: 1'b0, sat: 1'b0, p: 16'h0000, ovf: 1'b0},
        '{a: 16'h0001, b: 17'h0_2000, rnd: 1'b1, sat: 1'b0, p: 16'h0001, ovf: 1'b0},
        '{a: 16'h0001, b: 17'h1_2000, rnd: 1'b0, sat: 1'b0, p: 16'h0000, ovf: 1'b0},
        '{a: 16'h0001, b: 17'h1_2000, rnd: 1'b1, sat: 1'b0, p: 16'hFFFF, ovf: 1'b0},
        '{a: 16'h8000, b: 17'h0_4000, rnd: 1'b0, sat: 1'b1, p: 16'h8000, ovf: 1'b0},
        '{a: 16'h8000, b: 17'h1_4000, rnd: 1'b0, sat: 1'b1, p: 16'h7FFF, ovf: 1'b1},
        '{a: 16'h8000, b: 17'h1_4000, rnd: 1'b0, sat: 1'b0, p: 16'h8000, ovf: 1'b1},
        '{a: 16'h7FFF, b: 17'h0_FFFF, rnd: 1'b0, sat: 1'b1, p: 16'h7FFF, ovf: 1'b1},
        '{a: 16'h7FFF, b: 17'h0_FFFF, rnd: 1'b0, sat: 1'b0, p: 16'hFFFA, ovf: 1'b1},
        '{a: 16'h1234, b: 17'h1_0000, rnd: 1'b1, sat: 1'b1, p: 16'h0000, ovf: 1'b0},
        '{a: 16'hC000, b: 17'h0_6000, rnd: 1'b0, sat: 1'b0, p: 16'hA000, ovf: 1'b0},
        '{a: 16'h0003, b: 17'h0_2000, rnd: 1'b1, sat: 1'b0, p: 16'h0002, ovf: 1'b0},
        '{a: 16'h0003, b: 17'h0_2000, rnd: 1'b0, sat: 1'b0, p: 16'h0001, ovf: 1'b0}
    };

    initial begin
        logic [15:0] ra, rp;
        logic [16:0] rb;
        logic        rr, rs, ro;
        int          quiet;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_p", {16'd0, out_p}, 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        latency_check(16'h4000, 17'h0_2000, 16'h2000, 1'b0);
        drain();

        foreach (dir_vecs[i]) begin
            send(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].rnd, dir_vecs[i].sat,
                 dir_vecs[i].p, dir_vecs[i].ovf);
        end
        idle();
        drain();

        // Backpressure: item k is 1.0 * k/4 -> 0x1000*k
        bp_mode = 1;
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            send(16'h4000, {1'b0, 16'(k * 16'h1000)}, 1'b0, 1'b0, 16'(k * 16'h1000), 1'b0);
        end
        fork
            begin
                for (int k = 4; k <= 6; k++) begin
                    send(16'h4000, {1'b0, 16'(k * 16'h1000)}, 1'b0, 1'b0, 16'(k * 16'h1000), 1'b0);
                end
                idle();
            end
            begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    #1;
                    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                    chk("bp_out_p_hold", {16'd0, out_p}, 32'h1000);
                end
                bp_mode = 0;
            end
        join
        drain();

        // Random stream with random backpressure and input gaps
        bp_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            ra = 16'($urandom);
            rb = 17'($urandom);
            rr = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rr, rs, rp, ro);
            send(ra, rb, rr, rs, rp, ro);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        drain();

        // Asynchronous reset with a full, stalled pipe
        bp_mode = 1;
        @(negedge clk);
        for (int k = 1; k <= 3; k++) send(16'h4000, 17'h0_4000, 1'b0, 1'b0, 16'h4000, 1'b0);
        idle();
        #1;
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_out_p", {16'd0, out_p}, 32'd0);
        chk("async_rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        exp_q.delete();
        bp_mode = 0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        quiet = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) quiet++;
        end
        chk("no_output_after_reset", quiet, 32'd0);
        latency_check(16'hC000, 17'h0_6000, 16'hA000, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
